// File: rtl/sy_ppl_wb_arb.sv
// Write-back arbiter for the single register-file write port.
// ALU results win the port with zero latency; MDU results wait in a small
// FIFO and drain whenever the port is free. A starvation counter forces the
// FIFO head out after STARVE_MAX consecutive ALU-won cycles. Queued writes
// that are overwritten by a younger ALU write (WAW) are squashed in place.
module sy_ppl_wb_arb #(
  parameter int MDU_DEPTH  = 2,
  parameter int STARVE_MAX = 4,
  parameter int DWTH       = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            alu_wb__rdst_en_i,
  input  logic [4:0]      alu_wb__rdst_idx_i,
  input  logic [DWTH-1:0] alu_wb__rdst_data_i,
  output logic            wb_alu__ready_o,
  input  logic            mdu_wb__rdst_en_i,
  input  logic [4:0]      mdu_wb__rdst_idx_i,
  input  logic [DWTH-1:0] mdu_wb__rdst_data_i,
  output logic            wb_mdu__ready_o,
  output logic            wb_reg__rdst_en_o,
  output logic [4:0]      wb_reg__rdst_idx_o,
  output logic [DWTH-1:0] wb_reg__rdst_data_o,
  input  logic [4:0]      dec_wb__rs1_idx_i,
  input  logic [4:0]      dec_wb__rs2_idx_i,
  output logic            wb_dec__rs1_pend_o,
  output logic            wb_dec__rs2_pend_o,
  output logic            wb__mdu_empty_o
);

  localparam int AW = (MDU_DEPTH > 1) ? $clog2(MDU_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(MDU_DEPTH);
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

  // FIFO storage; a live bit is only ever set in an occupied slot
  logic [4:0]           r_idx  [MDU_DEPTH];
  logic [DWTH-1:0]      r_data [MDU_DEPTH];
  logic [MDU_DEPTH-1:0] r_live;
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic [SW-1:0]        r_starve;

  logic w_empty;
  logic w_full;
  logic w_alu_ready;
  logic w_alu_port;
  logic w_push;
  logic w_pop;
  logic w_rs1_pend;
  logic w_rs2_pend;

  assign w_empty     = (r_count == {CW{1'b0}});
  assign w_full      = (r_count == DEPTH_C);
  // Refuse the ALU for one cycle once it has starved a non-empty FIFO
  assign w_alu_ready = !((r_starve == STARVE_C) && !w_empty);
  // An accepted ALU write to x0 is swallowed without using the port
  assign w_alu_port  = alu_wb__rdst_en_i && w_alu_ready && (alu_wb__rdst_idx_i != 5'd0);
  // Ready depends on registered state only: a full FIFO refuses even if it pops now
  assign w_push      = mdu_wb__rdst_en_i && !w_full;
  assign w_pop       = !w_empty && !w_alu_port;

  assign wb_alu__ready_o    = w_alu_ready;
  assign wb_mdu__ready_o    = !w_full;
  assign wb__mdu_empty_o    = w_empty;
  assign wb_dec__rs1_pend_o = w_rs1_pend;
  assign wb_dec__rs2_pend_o = w_rs2_pend;

  // Port mux: ALU first, then the FIFO head (dead heads still occupy the port)
  always_comb begin
    wb_reg__rdst_en_o   = 1'b0;
    wb_reg__rdst_idx_o  = 5'd0;
    wb_reg__rdst_data_o = {DWTH{1'b0}};
    if (w_alu_port) begin
      wb_reg__rdst_en_o   = 1'b1;
      wb_reg__rdst_idx_o  = alu_wb__rdst_idx_i;
      wb_reg__rdst_data_o = alu_wb__rdst_data_i;
    end else if (!w_empty) begin
      wb_reg__rdst_en_o   = r_live[r_rd_ptr];
      wb_reg__rdst_idx_o  = r_idx[r_rd_ptr];
      wb_reg__rdst_data_o = r_data[r_rd_ptr];
    end else begin
      wb_reg__rdst_en_o   = 1'b0;
      wb_reg__rdst_idx_o  = 5'd0;
      wb_reg__rdst_data_o = {DWTH{1'b0}};
    end
  end

  // Hazard flags for decode: any live queued write matching a source register
  always_comb begin
    w_rs1_pend = 1'b0;
    w_rs2_pend = 1'b0;
    for (int i = 0; i < MDU_DEPTH; i++) begin
      w_rs1_pend = w_rs1_pend | (r_live[i] & (r_idx[i] == dec_wb__rs1_idx_i));
      w_rs2_pend = w_rs2_pend | (r_live[i] & (r_idx[i] == dec_wb__rs2_idx_i));
    end
    w_rs1_pend = w_rs1_pend & (dec_wb__rs1_idx_i != 5'd0);
    w_rs2_pend = w_rs2_pend & (dec_wb__rs2_idx_i != 5'd0);
  end

  // FIFO, squash and starvation state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < MDU_DEPTH; i++) begin
        r_idx[i]  <= 5'd0;
        r_data[i] <= {DWTH{1'b0}};
      end
      r_live   <= {MDU_DEPTH{1'b0}};
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
      r_starve <= {SW{1'b0}};
    end else begin
      // Older queued writes to the same register are now stale
      for (int i = 0; i < MDU_DEPTH; i++) begin
        if (w_alu_port && (r_idx[i] == alu_wb__rdst_idx_i)) begin
          r_live[i] <= 1'b0;
        end else begin
          r_live[i] <= r_live[i];
        end
      end
      if (w_pop) begin
        r_live[r_rd_ptr] <= 1'b0;
        r_rd_ptr         <= r_rd_ptr + AW'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      // Written after the squash so a same-cycle enqueue counts as younger
      if (w_push) begin
        r_idx[r_wr_ptr]  <= mdu_wb__rdst_idx_i;
        r_data[r_wr_ptr] <= mdu_wb__rdst_data_i;
        r_live[r_wr_ptr] <= (mdu_wb__rdst_idx_i != 5'd0);
        r_wr_ptr         <= r_wr_ptr + AW'(1);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_pop || w_empty) begin
        r_starve <= {SW{1'b0}};
      end else if (w_alu_port) begin
        r_starve <= r_starve + SW'(1);
      end else begin
        r_starve <= r_starve;
      end
    end
  end

endmodule
